uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-frame controller for the serial receiver. It runs on the 16x-data-rate clock and sequences the bit-sampling counter (bsc) by driving its enable. It uses the counter's 4-bit sample index to find the start bit, sample each data, parity and stop bit at mid-bit, and assemble the character. Completed characters are held in an output register with a valid/acknowledge handshake, plus framing, parity and overrun status.

## Interface
- DATA_BITS, 8, data bits per frame, 5..8, LSB first
- PARITY_EN, 0, 1 = one parity bit follows the data bits
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0

- clk  in  1  16x data-rate clock
- rst  in  1  asynchronous, active-high reset
- rxd  in  1  raw serial line, idle high, asynchronous to clk
- bitProgress  in  4  bsc sample index: 0..15 while enabled; 0 the cycle after enable is low
- rdAck  in  1  consumer has taken rxData (pulse)
- bscEnable  out  1  registered enable to bsc; 1 in every state except IDLE
- rxData  out  DATA_BITS  last completed character
- rxValid  out  1  rxData holds an unread character
- frameErr  out  1  stop bit of the current rxData sampled 0
- parityErr  out  1  parity mismatch on the current rxData; 0 when PARITY_EN=0
- overrun  out  1  sticky; a character completed while rxValid=1
- busy  out  1  frame in progress (state != IDLE)

## Operation
- rxd passes through a 2-flop synchronizer (rxS), then a 1-flop delayed copy (rxP). Start edge = rxS==0 && rxP==1. Both flops reset to 1.
- States: IDLE, START, DATA, PARITY, STOP. bscEnable and busy are registered and equal (next state != IDLE).
- Mid-bit sample: taken on the edge where bitProgress==7. Bit end: the edge where bitProgress==15. The counter wraps 15->0 on its own while enabled.
- IDLE: on a start edge -> START.
- START:
  - Mid-bit, rxS==1 -> false start, -> IDLE. No flags change.
  - Bit end -> DATA, bitCnt=0.
- DATA:
  - Mid-bit: shift rxS into the shift register MSB side, so the first bit ends at bit 0.
  - Bit end: bitCnt==DATA_BITS-1 -> PARITY if PARITY_EN, else STOP; otherwise bitCnt+1.
- PARITY:
  - Mid-bit: store rxS.
  - Bit end -> STOP.
- STOP, mid-bit (completion):
  - rxData <= shift register; rxValid <= 1.
  - frameErr <= ~rxS.
  - parityErr <= (XOR of data bits ^ parity bit ^ PARITY_ODD) when PARITY_EN, else 0.
  - overrun <= 1 if rxValid was 1 and rdAck is 0 on this edge.
  - -> IDLE the same edge. The controller does not wait for the stop-bit end, so back-to-back frames resynchronize.
- rdAck with no completion on the same edge: rxValid <= 0, overrun <= 0. rxData, frameErr and parityErr hold.
- rdAck and completion on the same edge: the new character loads, rxValid stays 1, overrun is not set.
- rdAck while rxValid=0: no effect.
- In IDLE, rxd held low produces no new start edge until rxd returns high.

## Timing
- Reset (async): state IDLE, bscEnable=0, busy=0, rxData=0, rxValid=0, frameErr=0, parityErr=0, overrun=0, bitCnt=0, shift register 0.
- Reset mid-frame: the frame is abandoned and no flags are set. bsc shares rst, so the counter also restarts at 0.
- rxd falls before edge A -> START entered at edge E0 = A+2. bscEnable rises at E0; bitProgress=0 for the cycle after E0.
- START mid-sample at edge E0+8. Bit k (k = 0 for start) is sampled at E0+8+16k.
- Completion edge is E0+8+16·(1+DATA_BITS+PARITY_EN): 8N1 = E0+152; 8E1 = E0+168.
- Outputs update on the completion edge. IDLE is entered on that same edge, and the earliest next start is at the following edge.

## Test plan
1. 8N1, 16 clk/bit: send 0x55 with a valid stop bit -> rxValid rises at E0+152; rxData=0x55; frameErr=0; parityErr=0; busy low from that edge.
2. PARITY_EN=1, PARITY_ODD=0: send 0xA3 with parity bit 0 -> rxData=0xA3, parityErr=0. Resend with parity bit 1 -> parityErr=1, rxData=0xA3.
3. rxd low for 3 clocks, then high -> START entered, aborted at E0+8; bscEnable back to 0; rxValid, frameErr and overrun unchanged.
4. Send 0x3C with the stop bit driven 0 -> rxData=0x3C, frameErr=1. Line returns high, then send 0x81 -> frameErr=0.
5. Overrun:
   - Two back-to-back frames 0x11, 0x22, no rdAck -> rxData=0x22, overrun=1.
   - Pulse rdAck -> rxValid=0, overrun=0.
   - rdAck coincident with completion -> rxValid stays 1, overrun=0.
6. Assert rst at data bit 4 of a frame -> all outputs 0 immediately, bscEnable=0. Release and send 0x7E -> received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-frame controller for the serial receiver.
// Runs on the 16x data-rate clock. It drives the enable of the bit-sampling
// counter (bsc), uses the counter's sample index to find the start bit, and
// samples data, parity and stop bits at mid-bit. Each completed character is
// held in an output register with a valid/acknowledge handshake and status.
//
// Ports:
//   clk          16x data-rate clock
//   rst          asynchronous, active-high reset
//   rxd          raw serial line, idle high, asynchronous to clk
//   bitProgress  bsc sample index (0..15 while enabled)
//   rdAck        consumer has taken rxData (pulse)
//   bscEnable    registered enable to bsc, high in every state except IDLE
//   rxData       last completed character
//   rxValid      rxData holds an unread character
//   frameErr     stop bit of the current rxData sampled 0
//   parityErr    parity mismatch on the current rxData
//   overrun      sticky, a character completed while rxValid was set
//   busy         frame in progress
module uart_rx_ctrl #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic [3:0]           bitProgress,
  input  logic                 rdAck,
  output logic                 bscEnable,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 rxValid,
  output logic                 frameErr,
  output logic                 parityErr,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic        PAR_ON  = (PARITY_EN != 0);
  localparam logic        PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta, rx_s, rx_p;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q;

  logic mid_bit, bit_end, start_edge;
  logic shift_en, par_en, cnt_clr, cnt_inc, complete;

  assign mid_bit    = (bitProgress == 4'd7);
  assign bit_end    = (bitProgress == 4'd15);
  assign start_edge = ~rx_s & rx_p;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_p    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      rx_p    <= rx_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    par_en   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) state_d = START;
      end
      START: begin
        if (mid_bit && rx_s) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
          cnt_clr = 1'b1;
        end
      end
      DATA: begin
        shift_en = mid_bit;
        if (bit_end) begin
          if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) state_d = PAR_ON ? PARITY : STOP;
          else                                    cnt_inc = 1'b1;
        end
      end
      PARITY: begin
        par_en = mid_bit;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Complete at stop mid-bit so back-to-back frames can resynchronize.
        if (mid_bit) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit counter, shift register and parity capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
    end else begin
      if (cnt_clr)      bit_cnt_q <= '0;
      else if (cnt_inc) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      if (shift_en)     shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
      if (par_en)       par_bit_q <= rx_s;
    end
  end

  // Enable/busy follow the next state so bsc starts counting on START entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bscEnable <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bscEnable <= (state_d != IDLE);
      busy      <= (state_d != IDLE);
    end
  end

  // Output character register and handshake/status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxData    <= '0;
      rxValid   <= 1'b0;
      frameErr  <= 1'b0;
      parityErr <= 1'b0;
      overrun   <= 1'b0;
    end else if (complete) begin
      rxData    <= shift_q;
      rxValid   <= 1'b1;
      frameErr  <= ~rx_s;
      parityErr <= PAR_ON & (^shift_q ^ par_bit_q ^ PAR_ODD);
      if (rxValid && !rdAck) overrun <= 1'b1;
      else if (rdAck)        overrun <= 1'b0;
    end else if (rdAck && rxValid) begin
      rxValid <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: one 8N1 instance (ch0) and one 8E1 instance (ch1),
// each with a small bsc model. Directed frames push expected characters into a
// per-channel queue; a monitor pops and compares whenever a frame ends.
module tb_uart_rx_ctrl;

  typedef struct {
    bit         abort;
    logic [7:0] data;
    bit         v;
    bit         fe;
    bit         pe;
    bit         ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd0 = 1'b1, rxd1 = 1'b1;
  logic ack0 = 1'b0, ack1 = 1'b0;
  logic [3:0] bp0, bp1;
  logic en0, en1, val0, val1, fe0, fe1, pe0, pe1, ov0, ov1, busy0, busy1;
  logic [7:0] dat0, dat1;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_n (
    .clk(clk), .rst(rst), .rxd(rxd0), .bitProgress(bp0), .rdAck(ack0),
    .bscEnable(en0), .rxData(dat0), .rxValid(val0), .frameErr(fe0),
    .parityErr(pe0), .overrun(ov0), .busy(busy0)
  );

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_e (
    .clk(clk), .rst(rst), .rxd(rxd1), .bitProgress(bp1), .rdAck(ack1),
    .bscEnable(en1), .rxData(dat1), .rxValid(val1), .frameErr(fe1),
    .parityErr(pe1), .overrun(ov1), .busy(busy1)
  );

  // bsc models: count while enabled, hold 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp0 <= 4'd0;
      bp1 <= 4'd0;
    end else begin
      bp0 <= en0 ? bp0 + 4'd1 : 4'd0;
      bp1 <= en1 ? bp1 + 4'd1 : 4'd0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic judge(input string tag, input exp_t e, input int hi, input int full,
                       input logic v, input logic [7:0] d, input logic fe,
                       input logic pe, input logic ov);
    if (e.abort) chk({tag, " abort len"}, hi, 8);
    else begin
      chk({tag, " frame len"}, hi, full);
      chk({tag, " data"}, d, e.data);
    end
    chk({tag, " valid"}, v, e.v);
    chk({tag, " frameErr"}, fe, e.fe);
    chk({tag, " parityErr"}, pe, e.pe);
    chk({tag, " overrun"}, ov, e.ov);
  endtask

  // Monitors: a frame ends when busy falls outside reset.
  int hi0 = 0, hi1 = 0;
  bit pb0 = 0, pb1 = 0;
  exp_t m0, m1;

  always @(negedge clk) begin
    if (rst) begin
      hi0 = 0;
      pb0 = 0;
    end else begin
      if (busy0) hi0++;
      else if (pb0) begin
        if (q0.size() == 0) chk("ch0 unexpected frame end", 1, 0);
        else begin
          m0 = q0.pop_front();
          judge("ch0", m0, hi0, 152, val0, dat0, fe0, pe0, ov0);
        end
        hi0 = 0;
      end
      pb0 = busy0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hi1 = 0;
      pb1 = 0;
    end else begin
      if (busy1) hi1++;
      else if (pb1) begin
        if (q1.size() == 0) chk("ch1 unexpected frame end", 1, 0);
        else begin
          m1 = q1.pop_front();
          judge("ch1", m1, hi1, 168, val1, dat1, fe1, pe1, ov1);
        end
        hi1 = 0;
      end
      pb1 = busy1;
    end
  end

  task automatic push(input int ch, input bit abort, input logic [7:0] d,
                      input bit v, input bit fe, input bit pe, input bit ov);
    exp_t e;
    e.abort = abort; e.data = d; e.v = v; e.fe = fe; e.pe = pe; e.ov = ov;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic set_rxd(input int ch, input logic v);
    if (ch == 0) rxd0 = v;
    else         rxd1 = v;
  endtask

  task automatic send(input int ch, input logic [7:0] d, input logic par, input logic stop);
    @(negedge clk);
    set_rxd(ch, 1'b0);
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rxd(ch, d[i]);
      repeat (16) @(negedge clk);
    end
    if (ch == 1) begin
      set_rxd(ch, par);
      repeat (16) @(negedge clk);
    end
    set_rxd(ch, stop);
    repeat (16) @(negedge clk);
    set_rxd(ch, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack(input int ch);
    @(negedge clk);
    if (ch == 0) ack0 = 1'b1; else ack1 = 1'b1;
    @(negedge clk);
    if (ch == 0) ack0 = 1'b0; else ack1 = 1'b0;
  endtask

  // Raise ack0 so it is sampled exactly on the completion edge E0+152.
  task automatic ack_on_completion();
    int n;
    n = 0;
    while (!busy0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!busy0) chk("ch0 start not seen", 0, 1);
    else begin
      repeat (151) @(negedge clk);
      ack0 = 1'b1;
      @(negedge clk);
      ack0 = 1'b0;
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #3;
    chk("reset ch0 outputs", {24'd0, dat0}, 32'd0);
    chk("reset ch0 flags", {en0, val0, fe0, pe0, ov0, busy0}, 0);
    chk("reset ch1 flags", {en1, val1, fe1, pe1, ov1, busy1}, 0);
    #12 rst = 1'b0;
    idle(4);

    // 8N1 basic character.
    push(0, 0, 8'h55, 1, 0, 0, 0);
    send(0, 8'h55, 1'b0, 1'b1);
    idle(4);
    ack(0);
    chk("ack clears valid", val0, 0);
    chk("ack holds data", dat0, 8'h55);

    // 8E1: correct parity, then wrong parity.
    push(1, 0, 8'hA3, 1, 0, 0, 0);
    send(1, 8'hA3, 1'b0, 1'b1);
    idle(4);
    ack(1);
    push(1, 0, 8'hA3, 1, 0, 1, 0);
    send(1, 8'hA3, 1'b1, 1'b1);
    idle(4);
    ack(1);
    chk("ch1 ack holds parityErr", pe1, 1);

    // Framing error, then a false start that must not disturb the flags.
    push(0, 0, 8'h3C, 1, 1, 0, 0);
    send(0, 8'h3C, 1'b0, 1'b0);
    idle(6);
    push(0, 1, 8'h00, 1, 1, 0, 0);
    @(negedge clk);
    rxd0 = 1'b0;
    idle(3);
    rxd0 = 1'b1;
    idle(20);
    chk("false start bscEnable low", en0, 0);
    ack(0);
    push(0, 0, 8'h81, 1, 0, 0, 0);
    send(0, 8'h81, 1'b0, 1'b1);
    idle(4);
    ack(0);

    // Overrun on back-to-back frames, cleared by ack.
    push(0, 0, 8'h11, 1, 0, 0, 0);
    send(0, 8'h11, 1'b0, 1'b1);
    push(0, 0, 8'h22, 1, 0, 0, 1);
    send(0, 8'h22, 1'b0, 1'b1);
    idle(4);
    ack(0);
    chk("ack clears overrun", ov0, 0);
    chk("ack clears valid after overrun", val0, 0);
    chk("data after overrun", dat0, 8'h22);

    // Ack coincident with completion: no overrun, valid stays.
    push(0, 0, 8'h44, 1, 0, 0, 0);
    send(0, 8'h44, 1'b0, 1'b1);
    idle(4);
    push(0, 0, 8'h5A, 1, 0, 0, 0);
    fork
      send(0, 8'h5A, 1'b0, 1'b1);
      ack_on_completion();
    join
    idle(4);
    chk("coincident ack keeps valid", val0, 1);

    // Reset at data bit 4 of a frame.
    @(negedge clk);
    rxd0 = 1'b0;
    idle(16);
    for (int i = 0; i < 4; i++) begin
      rxd0 = (i == 1);
      idle(16);
    end
    rxd0 = 1'b1;
    idle(8);
    chk("busy before mid-frame reset", busy0, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid-frame reset data", dat0, 8'h00);
    chk("mid-frame reset flags", {en0, val0, fe0, pe0, ov0, busy0}, 0);
    idle(2);
    #2 rst = 1'b0;
    idle(20);
    push(0, 0, 8'h7E, 1, 0, 0, 0);
    send(0, 8'h7E, 1'b0, 1'b1);

    for (int i = 0; i < 400 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    chk("ch0 queue drained", q0.size(), 0);
    chk("ch1 queue drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
